nios_timer_host: RTL and testbench

//  Avalon-MM initiator that drives the 16-bit interval-timer register map (period L/H, control,

---
 rtl/nios_timer_pkg.sv | 43 ++++
 rtl/nios_timer_host.sv | 168 ++++++++++++++++
 tb/tb_nios_timer_host.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_timer_pkg.sv
// Shared definitions for the interval-timer host: s1 register map, control bits, FSM states.
package nios_timer_pkg;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PER_L   = 3'd2;
    localparam logic [2:0] ADDR_PER_H   = 3'd3;
    localparam logic [2:0] ADDR_SNAP_L  = 3'd4;
    localparam logic [2:0] ADDR_SNAP_H  = 3'd5;

    localparam int unsigned CTRL_ITO   = 0;
    localparam int unsigned CTRL_CONT  = 1;
    localparam int unsigned CTRL_START = 2;
    localparam int unsigned CTRL_STOP  = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTRL,
        ST_RUN,
        ST_CLR_ST,
        ST_WR_SNAP,
        ST_RD_SL,
        ST_WAIT_L,
        ST_RD_SH,
        ST_WAIT_H,
        ST_SVC_DONE,
        ST_WR_STOP
    } state_t;

    // Interrupt enable is tied to START: a started timer always reports timeouts.
    function automatic logic [15:0] ctrl_word(input logic start, input logic cont, input logic stop);
        logic [15:0] w;
        w             = '0;
        w[CTRL_ITO]   = start;
        w[CTRL_CONT]  = cont;
        w[CTRL_START] = start;
        w[CTRL_STOP]  = stop;
        return w;
    endfunction

endpackage

// File: rtl/nios_timer_host.sv
// Avalon-MM initiator that programs, runs and services a 16-bit interval timer without a CPU.
module nios_timer_host
    import nios_timer_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter bit          SNAPSHOT_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_start,
    input  logic [31:0] cfg_period,
    input  logic        cfg_continuous,
    input  logic        cfg_stop,
    output logic        busy,
    output logic        tick,
    output logic [31:0] snap_value,
    output logic        snap_valid,
    output logic [2:0]  address,
    output logic        chipselect,
    output logic        write_n,
    output logic [15:0] writedata,
    input  logic [15:0] readdata,
    input  logic        irq
);

    localparam int unsigned LAT_EFF  = (READ_LATENCY == 0) ? 1 : READ_LATENCY;
    localparam logic [7:0]  LAT_LAST = 8'(LAT_EFF - 1);

    state_t      state_q, state_d;
    logic [31:0] period_q;
    logic        cont_q;
    logic        stop_pend_q, stop_pend_d;
    logic [7:0]  lat_q;
    logic        lat_done;
    logic [15:0] snap_l_q;
    logic [2:0]  addr_q;
    logic [15:0] wdata_q;
    logic        stop_req;

    assign lat_done = (lat_q == LAT_LAST);
    assign stop_req = cfg_stop | stop_pend_q;

    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        chipselect  = 1'b0;
        write_n     = 1'b1;
        address     = addr_q;
        writedata   = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) state_d = ST_WR_PL;
            end
            ST_WR_PL: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = ADDR_PER_L;
                writedata  = period_q[15:0];
                state_d    = ST_WR_PH;
            end
            ST_WR_PH: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = ADDR_PER_H;
                writedata  = period_q[31:16];
                state_d    = ST_WR_CTRL;
            end
            ST_WR_CTRL: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = ADDR_CONTROL;
                writedata  = ctrl_word(1'b1, cont_q, 1'b0);
                state_d    = stop_req ? ST_WR_STOP : ST_RUN;
            end
            // irq outranks stop; a stop arriving with irq stays latched until SVC_DONE.
            ST_RUN: begin
                if (irq)           state_d = ST_CLR_ST;
                else if (stop_req) state_d = ST_WR_STOP;
            end
            ST_CLR_ST: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = ADDR_STATUS;
                writedata  = '0;
                state_d    = SNAPSHOT_EN ? ST_WR_SNAP : ST_SVC_DONE;
            end
            ST_WR_SNAP: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = ADDR_SNAP_L;
                writedata  = '0;
                state_d    = ST_RD_SL;
            end
            ST_RD_SL: begin
                chipselect = 1'b1;
                address    = ADDR_SNAP_L;
                state_d    = ST_WAIT_L;
            end
            ST_WAIT_L: begin
                if (lat_done) state_d = ST_RD_SH;
            end
            ST_RD_SH: begin
                chipselect = 1'b1;
                address    = ADDR_SNAP_H;
                state_d    = ST_WAIT_H;
            end
            ST_WAIT_H: begin
                if (lat_done) state_d = ST_SVC_DONE;
            end
            ST_SVC_DONE: begin
                if (stop_req)    state_d = ST_WR_STOP;
                else if (cont_q) state_d = ST_RUN;
                else             state_d = ST_IDLE;
            end
            ST_WR_STOP: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = ADDR_CONTROL;
                writedata  = ctrl_word(1'b0, 1'b0, 1'b1);
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_IDLE && cfg_stop) stop_pend_d = 1'b1;
        if (state_d == ST_WR_STOP || state_d == ST_IDLE) stop_pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            stop_pend_q <= 1'b0;
            period_q    <= '0;
            cont_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
            addr_q      <= address;
            wdata_q     <= writedata;
            if (state_q == ST_IDLE && cfg_start) begin
                period_q <= cfg_period;
                cont_q   <= cfg_continuous;
            end
        end
    end

    // Read-latency counter; readdata is taken on the last idle cycle after the address cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_q      <= '0;
            snap_l_q   <= '0;
            snap_value <= '0;
        end else begin
            if ((state_q == ST_WAIT_L || state_q == ST_WAIT_H) && !lat_done) lat_q <= lat_q + 8'd1;
            else                                                            lat_q <= '0;
            if (state_q == ST_WAIT_L && lat_done) snap_l_q <= readdata;
            if (state_q == ST_WAIT_H && lat_done) snap_value <= {readdata, snap_l_q};
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign tick       = (state_q == ST_SVC_DONE);
    assign snap_valid = tick & SNAPSHOT_EN;

endmodule

// File: tb/tb_nios_timer_host.sv
// Scoreboard bench: host paired with a behavioural interval-timer slave (registered readdata).
module tb_nios_timer_host;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [31:0] cfg_period = '0;
    logic        cfg_continuous = 1'b0;
    logic        cfg_stop = 1'b0;
    logic        busy, tick, snap_valid, chipselect, write_n, irq;
    logic [31:0] snap_value;
    logic [2:0]  address;
    logic [15:0] writedata, readdata;

    always #5 clk = ~clk;

    nios_timer_host #(.READ_LATENCY(1), .SNAPSHOT_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_period(cfg_period),
        .cfg_continuous(cfg_continuous), .cfg_stop(cfg_stop), .busy(busy), .tick(tick),
        .snap_value(snap_value), .snap_valid(snap_valid), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .irq(irq)
    );

    // Timer slave model: counts period..0, sets TO, reloads; period writes stop and reload.
    logic [31:0] m_per, m_cnt, m_snap;
    logic        m_ito, m_cont, m_run, m_to;
    logic [15:0] m_rdata;
    assign irq      = m_to & m_ito;
    assign readdata = m_rdata;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_per <= '0; m_cnt <= '0; m_snap <= '0; m_ito <= 1'b0; m_cont <= 1'b0;
            m_run <= 1'b0; m_to <= 1'b0; m_rdata <= '0;
        end else begin
            if (chipselect && write_n) begin
                case (address)
                    3'd0: m_rdata <= {14'd0, m_run, m_to};
                    3'd1: m_rdata <= {14'd0, m_cont, m_ito};
                    3'd2: m_rdata <= m_per[15:0];
                    3'd3: m_rdata <= m_per[31:16];
                    3'd4: m_rdata <= m_snap[15:0];
                    3'd5: m_rdata <= m_snap[31:16];
                    default: m_rdata <= '0;
                endcase
            end
            if (m_run) begin
                if (m_cnt == 0) begin
                    m_to  <= 1'b1;
                    m_cnt <= m_per;
                    if (!m_cont) m_run <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_to <= 1'b0;
                    3'd1: begin
                        m_ito  <= writedata[0];
                        m_cont <= writedata[1];
                        if (writedata[2]) m_run <= 1'b1;
                        if (writedata[3]) m_run <= 1'b0;
                    end
                    3'd2: begin m_per[15:0]  <= writedata; m_cnt <= {m_per[31:16], writedata}; m_run <= 1'b0; end
                    3'd3: begin m_per[31:16] <= writedata; m_cnt <= {writedata, m_per[15:0]};  m_run <= 1'b0; end
                    3'd4, 3'd5: m_snap <= m_cnt;
                    default: ;
                endcase
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // kind 0 = write, 1 = read, 2 = tick (data = upper bound on snapshot)
    typedef struct {
        int          kind;
        logic [2:0]  addr;
        logic [31:0] data;
    } ev_t;
    ev_t exp_q[$];
    int  tick_times[$];

    task automatic push_w(input logic [2:0] a, input logic [31:0] d);
        ev_t e; e.kind = 0; e.addr = a; e.data = d; exp_q.push_back(e);
    endtask
    task automatic push_r(input logic [2:0] a);
        ev_t e; e.kind = 1; e.addr = a; e.data = '0; exp_q.push_back(e);
    endtask
    task automatic push_start(input logic [31:0] per, input logic cont);
        push_w(3'd2, {16'd0, per[15:0]});
        push_w(3'd3, {16'd0, per[31:16]});
        push_w(3'd1, cont ? 32'h7 : 32'h5);
    endtask
    task automatic push_svc(input logic [31:0] bound);
        ev_t e;
        push_w(3'd0, 32'h0);
        push_w(3'd4, 32'h0);
        push_r(3'd4);
        push_r(3'd5);
        e.kind = 2; e.addr = '0; e.data = bound; exp_q.push_back(e);
    endtask

    ev_t me;
    always @(negedge clk) begin
        if (reset_n && (chipselect || tick)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_event: cs=%0b wn=%0b addr=%0d wd=0x%0h tick=%0b, required no activity (cycle %0d)",
                         chipselect, write_n, address, writedata, tick, cyc);
            end else begin
                me = exp_q.pop_front();
                case (me.kind)
                    0: begin
                        chk("wr_strobe", {30'd0, chipselect, write_n}, 32'h2);
                        chk("wr_addr", {29'd0, address}, {29'd0, me.addr});
                        chk("wr_data", {16'd0, writedata}, me.data);
                    end
                    1: begin
                        chk("rd_strobe", {30'd0, chipselect, write_n}, 32'h3);
                        chk("rd_addr", {29'd0, address}, {29'd0, me.addr});
                    end
                    default: begin
                        chk("tick", {31'd0, tick}, 32'h1);
                        chk("snap_valid", {31'd0, snap_valid}, 32'h1);
                        chk("snap_value", snap_value, m_snap);
                        chk("snap_bound", {31'd0, (snap_value <= me.data)}, 32'h1);
                        tick_times.push_back(cyc);
                    end
                endcase
            end
        end
    end

    task automatic pulse_start(input logic [31:0] per, input logic cont);
        @(negedge clk);
        cfg_start = 1'b1; cfg_period = per; cfg_continuous = cont;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, busy}, 32'h0);
    endtask

    initial begin
        int n;
        int seen;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_tick", {31'd0, tick}, 32'h0);
        chk("rst_snap_valid", {31'd0, snap_valid}, 32'h0);
        chk("rst_cs", {31'd0, chipselect}, 32'h0);
        chk("rst_write_n", {31'd0, write_n}, 32'h1);
        chk("rst_address", {29'd0, address}, 32'h0);
        chk("rst_writedata", {16'd0, writedata}, 32'h0);
        chk("rst_snap_value", snap_value, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // One-shot, period 0x10
        tick_times.delete();
        push_start(32'h10, 1'b0);
        push_svc(32'h10);
        pulse_start(32'h10, 1'b0);
        wait_idle("t1_busy_drop", 100);
        repeat (5) @(negedge clk);
        chk("t1_drain", exp_q.size(), 0);
        chk("t1_tick_count", tick_times.size(), 1);

        // Continuous, period 8, three ticks then stop in RUN
        tick_times.delete();
        push_start(32'h8, 1'b1);
        repeat (3) push_svc(32'h8);
        push_w(3'd1, 32'h8);
        pulse_start(32'h8, 1'b1);
        n = 0; seen = 0;
        while (seen < 3 && n < 300) begin
            @(negedge clk);
            n++;
            if (tick) seen++;
        end
        chk("t2_tick_count", seen, 3);
        @(negedge clk);
        cfg_stop = 1'b1;
        @(negedge clk);
        cfg_stop = 1'b0;
        @(negedge clk);
        chk("t2_busy_after_stop", {31'd0, busy}, 32'h0);
        if (tick_times.size() >= 3) begin
            chk("t2_spacing_a", tick_times[1] - tick_times[0], 9);
            chk("t2_spacing_b", tick_times[2] - tick_times[1], 9);
        end else begin
            chk("t2_spacing_ticks", tick_times.size(), 3);
        end
        repeat (40) @(negedge clk);
        chk("t2_drain", exp_q.size(), 0);
        chk("t2_no_more_ticks", tick_times.size(), 3);

        // Stop during WR_PH: control write completes, then stop write
        tick_times.delete();
        push_start(32'h0001_2345, 1'b0);
        push_w(3'd1, 32'h8);
        @(negedge clk);
        cfg_start = 1'b1; cfg_period = 32'h0001_2345; cfg_continuous = 1'b0;
        @(negedge clk);
        cfg_start = 1'b0;
        @(negedge clk);
        cfg_stop = 1'b1;
        @(negedge clk);
        cfg_stop = 1'b0;
        wait_idle("t3_busy_drop", 20);
        repeat (30) @(negedge clk);
        chk("t3_drain", exp_q.size(), 0);
        chk("t3_no_ticks", tick_times.size(), 0);

        // Period 0, second start while busy ignored, then stop in IDLE ignored
        tick_times.delete();
        push_start(32'h0, 1'b0);
        push_svc(32'h0);
        @(negedge clk);
        cfg_start = 1'b1; cfg_period = 32'h0; cfg_continuous = 1'b0;
        @(negedge clk);
        cfg_start = 1'b0;
        @(negedge clk);
        cfg_start = 1'b1; cfg_period = 32'hFFFF_FFFF; cfg_continuous = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0; cfg_period = '0; cfg_continuous = 1'b0;
        wait_idle("t5_busy_drop", 100);
        repeat (10) @(negedge clk);
        cfg_stop = 1'b1;
        @(negedge clk);
        cfg_stop = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5_idle_stop_busy", {31'd0, busy}, 32'h0);
        chk("t5_drain", exp_q.size(), 0);
        chk("t5_tick_count", tick_times.size(), 1);

        // irq and stop in the same RUN cycle: service first, then stop
        tick_times.delete();
        push_start(32'h20, 1'b1);
        push_svc(32'h20);
        push_w(3'd1, 32'h8);
        pulse_start(32'h20, 1'b1);
        n = 0;
        while (!irq && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t4_irq_seen", {31'd0, irq}, 32'h1);
        cfg_stop = 1'b1;
        @(negedge clk);
        cfg_stop = 1'b0;
        wait_idle("t4_busy_drop", 100);
        repeat (60) @(negedge clk);
        chk("t4_drain", exp_q.size(), 0);
        chk("t4_tick_count", tick_times.size(), 1);

        // Reset asserted during RD_SL releases the bus at once
        push_start(32'h8, 1'b0);
        push_w(3'd0, 32'h0);
        push_w(3'd4, 32'h0);
        push_r(3'd4);
        pulse_start(32'h8, 1'b0);
        n = 0;
        while (!(chipselect && write_n && address == 3'd4) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reached_rd_sl", {31'd0, (chipselect && write_n && address == 3'd4)}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_cs", {31'd0, chipselect}, 32'h0);
        chk("t6_rst_write_n", {31'd0, write_n}, 32'h1);
        chk("t6_rst_busy", {31'd0, busy}, 32'h0);
        chk("t6_rst_snap_valid", {31'd0, snap_valid}, 32'h0);
        chk("t6_drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
